// File: rtl/apb_gpio_v2.sv
// APB GPIO peripheral: atomic OUT set/clear/toggle, 2-flop input sync, per-pin edge/level IRQ.
// Define GPIO_DEBOUNCE_EN to add the input debounce filter and the DEBOUNCE register at 0x2C.
//
// state    | meaning
// S_IDLE   | no transfer in progress; waiting for an APB setup phase
// S_ACCESS | address captured; pready high, write commits on the closing edge
module apb_gpio_v2 #(
  parameter int NUM_GPIO      = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int DB_CNT_W      = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr,
  input  logic [NUM_GPIO-1:0]      gpio_i,
  output logic [NUM_GPIO-1:0]      gpio_o,
  output logic [NUM_GPIO-1:0]      gpio_oe,
  output logic                     irq_o
);

  localparam logic [ADDRESS_WIDTH-1:0] A_DIR   = ADDRESS_WIDTH'('h00);
  localparam logic [ADDRESS_WIDTH-1:0] A_OUT   = ADDRESS_WIDTH'('h04);
  localparam logic [ADDRESS_WIDTH-1:0] A_SET   = ADDRESS_WIDTH'('h08);
  localparam logic [ADDRESS_WIDTH-1:0] A_CLR   = ADDRESS_WIDTH'('h0C);
  localparam logic [ADDRESS_WIDTH-1:0] A_TGL   = ADDRESS_WIDTH'('h10);
  localparam logic [ADDRESS_WIDTH-1:0] A_IN    = ADDRESS_WIDTH'('h14);
  localparam logic [ADDRESS_WIDTH-1:0] A_EN    = ADDRESS_WIDTH'('h18);
  localparam logic [ADDRESS_WIDTH-1:0] A_TYPE  = ADDRESS_WIDTH'('h1C);
  localparam logic [ADDRESS_WIDTH-1:0] A_POL   = ADDRESS_WIDTH'('h20);
  localparam logic [ADDRESS_WIDTH-1:0] A_BOTH  = ADDRESS_WIDTH'('h24);
  localparam logic [ADDRESS_WIDTH-1:0] A_STAT  = ADDRESS_WIDTH'('h28);
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [ADDRESS_WIDTH-1:0] A_DB    = ADDRESS_WIDTH'('h2C);
`endif

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                     state_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic                       write_q;

  logic [NUM_GPIO-1:0] dir_q, out_q, irq_en_q, irq_type_q, irq_pol_q, irq_both_q, irq_stat_q;
  logic [NUM_GPIO-1:0] sync1_q, in_sync, prev_q, filt;
  logic [NUM_GPIO-1:0] rise, fall, edge_evt, lvl_evt, evt, w1c;
  logic [1:0]          start_cnt_q;
  logic                arm;

  logic                  access, mapped, wr_en;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [NUM_GPIO-1:0]   wdata;

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0]         db_q, pre_q;
  logic [NUM_GPIO-1:0]         filt_q;
  logic [NUM_GPIO-1:0][1:0]    dcnt_q;
  logic                        bypass, tick;
`endif

  assign access = (state_q == S_ACCESS);
  assign wdata  = pwdata[NUM_GPIO-1:0];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (psel && !penable) begin
            state_q <= S_ACCESS;
            addr_q  <= paddr;
            write_q <= pwrite;
          end
        end
        S_ACCESS: begin
          if (psel && penable) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (addr_q)
      A_DIR:                 rd_val = DATA_WIDTH'(dir_q);
      A_OUT:                 rd_val = DATA_WIDTH'(out_q);
      A_SET, A_CLR, A_TGL:   rd_val = '0;
      A_IN:                  rd_val = DATA_WIDTH'(filt);
      A_EN:                  rd_val = DATA_WIDTH'(irq_en_q);
      A_TYPE:                rd_val = DATA_WIDTH'(irq_type_q);
      A_POL:                 rd_val = DATA_WIDTH'(irq_pol_q);
      A_BOTH:                rd_val = DATA_WIDTH'(irq_both_q);
      A_STAT:                rd_val = DATA_WIDTH'(irq_stat_q);
`ifdef GPIO_DEBOUNCE_EN
      A_DB:                  rd_val = DATA_WIDTH'(db_q);
`endif
      default:               mapped = 1'b0;
    endcase
  end

  assign pready  = access;
  assign pslverr = access & ~mapped;
  assign prdata  = (access && mapped) ? rd_val : '0;
  assign wr_en   = access & write_q & psel & penable & mapped;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      dir_q      <= '0;
      out_q      <= '0;
      irq_en_q   <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
      irq_both_q <= '0;
    end else if (wr_en) begin
      case (addr_q)
        A_DIR:   dir_q      <= wdata;
        A_OUT:   out_q      <= wdata;
        A_SET:   out_q      <= out_q | wdata;
        A_CLR:   out_q      <= out_q & ~wdata;
        A_TGL:   out_q      <= out_q ^ wdata;
        A_EN:    irq_en_q   <= wdata;
        A_TYPE:  irq_type_q <= wdata;
        A_POL:   irq_pol_q  <= wdata;
        A_BOTH:  irq_both_q <= wdata;
        default: ;
      endcase
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync1_q <= '0;
      in_sync <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpio_i;
      in_sync <= sync1_q;
      prev_q  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  assign bypass = (db_q == '0);
  assign tick   = (pre_q == '0);
  assign filt   = bypass ? in_sync : filt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      db_q <= '0;
    end else if (wr_en && addr_q == A_DB) begin
      db_q <= pwdata[DB_CNT_W-1:0];
    end
  end

  // Prescaler counts down from DEBOUNCE; terminal count is the sample tick.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre_q <= '0;
    end else if (bypass || tick) begin
      pre_q <= db_q;
    end else begin
      pre_q <= pre_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      filt_q <= '0;
      dcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (bypass) begin
          filt_q[i] <= in_sync[i];
          dcnt_q[i] <= 2'd0;
        end else if (tick) begin
          if (in_sync[i] == filt_q[i]) begin
            dcnt_q[i] <= 2'd0;
          end else if (dcnt_q[i] == 2'd2) begin
            filt_q[i] <= in_sync[i];
            dcnt_q[i] <= 2'd0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + 2'd1;
          end
        end
      end
    end
  end
`else
  assign filt = in_sync;
`endif

  // Hold off events until the sync chain has flushed out its reset value.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      start_cnt_q <= 2'd0;
    end else if (start_cnt_q != 2'd3) begin
      start_cnt_q <= start_cnt_q + 2'd1;
    end
  end
  assign arm = (start_cnt_q == 2'd3);

  assign rise     = filt & ~prev_q;
  assign fall     = ~filt & prev_q;
  assign edge_evt = (irq_both_q & (rise | fall)) |
                    (~irq_both_q & ((irq_pol_q & rise) | (~irq_pol_q & fall)));
  assign lvl_evt  = (irq_pol_q & filt) | (~irq_pol_q & ~filt);
  assign evt      = {NUM_GPIO{arm}} & ((irq_type_q & lvl_evt) | (~irq_type_q & edge_evt));
  assign w1c      = (wr_en && addr_q == A_STAT) ? wdata : '0;

  // A new event outranks a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_stat_q <= '0;
      irq_o      <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~w1c) | evt;
      irq_o      <= |(irq_stat_q & irq_en_q);
    end
  end

endmodule
